// File: rtl/vsynth_pkg.sv
// rtl/vsynth_pkg.sv - shared voice-synth types, phase width and top-octave increment table
package vsynth_pkg;

   localparam int PHASE_W = 7;

   typedef enum logic [1:0] {IDLE, DIVIDE, LOAD, RUN} state_t;

   // round(f(120+k) * 2^24 / 48000), notes C9..B9
   localparam logic [23:0] BASE_INC [12] = '{
      24'd2926232, 24'd3100235, 24'd3284585, 24'd3479896,
      24'd3686822, 24'd3906052, 24'd4138318, 24'd4384395,
      24'd4645104, 24'd4921317, 24'd5213953, 24'd5523991
   };

   function automatic logic [23:0] base_inc(input logic [3:0] k);
      return (k < 4'd12) ? BASE_INC[k] : 24'd0;
   endfunction

endpackage

// File: rtl/note_div12.sv
// rtl/note_div12.sv - sequential divide-by-12 of a MIDI note into octave and semitone
module note_div12 (
   input  logic       CLK,
   input  logic       RST,
   input  logic       start,
   input  logic [6:0] note,
   output logic [3:0] oct,
   output logic [3:0] semi,
   output logic       done
);

   logic [6:0] rem;
   logic       running;

   always_ff @(posedge CLK) begin
      if (RST) begin
         rem     <= '0;
         oct     <= '0;
         running <= 1'b0;
      end else if (start) begin
         rem     <= note;
         oct     <= '0;
         running <= 1'b1;
      end else if (running) begin
         if (rem >= 7'd12) begin
            rem <= rem - 7'd12;
            oct <= oct + 4'd1;
         end else begin
            running <= 1'b0;
         end
      end
   end

   assign done = running && (rem < 7'd12);
   assign semi = rem[3:0];

endmodule

// File: rtl/note2phase.sv
// rtl/note2phase.sv - note-on/off events to per-voice 7-bit phase stream
// Optional portamento enabled by defining NOTE2PHASE_GLIDE_EN.
module note2phase
   import vsynth_pkg::*;
#(
   parameter int ACC_W       = 24,
   parameter int FS_HZ       = 48000,
   parameter int GLIDE_SHIFT = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               CE,
   input  logic               NOTE_ON,
   input  logic               NOTE_OFF,
   input  logic [6:0]         NOTE,
   output logic [PHASE_W-1:0] PHASE,
   output logic               ACTIVE,
   output logic               BUSY
);

   // The increment table is only valid for this accumulator width and sample rate
   if (ACC_W != 24 || FS_HZ != 48000 || GLIDE_SHIFT >= ACC_W) begin : g_cfg_check
      $error("note2phase: BASE_INC table built for ACC_W=24, FS_HZ=48000");
   end

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] inc;
   logic [ACC_W-1:0] inc_load;
   logic [6:0]       note_q;
   logic             was_idle;
   logic [3:0]       div_oct;
   logic [3:0]       div_semi;
   logic             div_done;

   note_div12 u_div (
      .CLK   (CLK),
      .RST   (RST),
      .start (NOTE_ON),
      .note  (NOTE),
      .oct   (div_oct),
      .semi  (div_semi),
      .done  (div_done)
   );

   assign inc_load = ACC_W'(base_inc(div_semi) >> (4'd10 - div_oct));

`ifdef NOTE2PHASE_GLIDE_EN
   logic [ACC_W-1:0] target;
   logic [ACC_W-1:0] glide_diff;
   logic [ACC_W-1:0] glide_step;

   always_comb begin
      glide_diff = (target >= inc) ? (target - inc) : (inc - target);
      glide_step = glide_diff >> GLIDE_SHIFT;
      if (glide_step == '0)
         glide_step = {{(ACC_W-1){1'b0}}, 1'b1};
   end
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         acc      <= '0;
         inc      <= '0;
         note_q   <= '0;
         was_idle <= 1'b0;
         PHASE    <= '0;
`ifdef NOTE2PHASE_GLIDE_EN
         target   <= '0;
`endif
      end else begin
         PHASE <= acc[ACC_W-1 -: PHASE_W];
         if (NOTE_ON) begin
            note_q   <= NOTE;
            was_idle <= (state == IDLE);
            state    <= DIVIDE;
            // legato: a sounding voice keeps advancing on the old increment
            if (CE && state != IDLE)
               acc <= acc + inc;
         end else if (NOTE_OFF && NOTE == note_q && state != IDLE) begin
            state <= IDLE;
            acc   <= '0;
            inc   <= '0;
         end else begin
            case (state)
               IDLE: acc <= '0;
               DIVIDE: begin
                  if (CE)
                     acc <= acc + inc;
                  if (div_done)
                     state <= LOAD;
               end
               LOAD: begin
`ifdef NOTE2PHASE_GLIDE_EN
                  target <= inc_load;
                  if (was_idle)
                     inc <= inc_load;
`else
                  inc <= inc_load;
`endif
                  if (was_idle)
                     acc <= '0;
                  else if (CE)
                     acc <= acc + inc;
                  state <= RUN;
               end
               RUN: begin
                  if (CE) begin
                     acc <= acc + inc;
`ifdef NOTE2PHASE_GLIDE_EN
                     if (target > inc)
                        inc <= inc + glide_step;
                     else if (target < inc)
                        inc <= inc - glide_step;
`endif
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign ACTIVE = (state == RUN);
   assign BUSY   = (state == DIVIDE) || (state == LOAD);

endmodule

// File: tb/tb_note2phase.sv
// tb/tb_note2phase.sv - directed self-checking bench for note2phase
module tb_note2phase;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       CE = 1'b0;
   logic       NOTE_ON = 1'b0;
   logic       NOTE_OFF = 1'b0;
   logic [6:0] NOTE = '0;
   logic [6:0] PHASE;
   logic       ACTIVE;
   logic       BUSY;

   int checks = 0;
   int errors = 0;

   note2phase dut (
      .CLK      (CLK),
      .RST      (RST),
      .CE       (CE),
      .NOTE_ON  (NOTE_ON),
      .NOTE_OFF (NOTE_OFF),
      .NOTE     (NOTE),
      .PHASE    (PHASE),
      .ACTIVE   (ACTIVE),
      .BUSY     (BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic ce_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         CE = 1'b1;
         tick();
         CE = 1'b0;
         tick();
      end
   endtask

   task automatic strobe_on(input logic [6:0] n);
      NOTE = n;
      NOTE_ON = 1'b1;
      tick();
      NOTE_ON = 1'b0;
   endtask

   task automatic strobe_off(input logic [6:0] n);
      NOTE = n;
      NOTE_OFF = 1'b1;
      tick();
      NOTE_OFF = 1'b0;
   endtask

   // cycles spent busy after the NOTE_ON edge; 40 means it never went active
   task automatic wait_active(output int n);
      n = 0;
      while (!ACTIVE && n < 40) begin
         tick();
         n++;
      end
   endtask

   int         n;
   logic [7:0] idle_or;
   logic       seen_idle;
   logic       mono_bad;
   logic [31:0] prev_inc;

   initial begin
      // reset and quiet idle
      tick();
      tick();
      RST = 1'b0;
      check("rst_phase", 32'(PHASE), 0);
      check("rst_active", 32'(ACTIVE), 0);
      check("rst_busy", 32'(BUSY), 0);
      idle_or = '0;
      for (int i = 0; i < 100; i++) begin
         CE = i[0];
         tick();
         idle_or = idle_or | {PHASE, ACTIVE | BUSY};
      end
      CE = 1'b0;
      check("idle_quiet", 32'(idle_or), 0);

      // A4: 6 DIVIDE + 1 LOAD, inc 153791, 1000 CE -> acc 2796056, PHASE 21
      strobe_on(7'd69);
      wait_active(n);
      check("a4_busy_cycles", 32'(n), 7);
      check("a4_inc", 32'(dut.inc), 153791);
      check("a4_acc_start", 32'(dut.acc), 0);
      ce_pulses(1000);
      check("a4_acc_1000", 32'(dut.acc), 2796056);
      check("a4_phase", 32'(PHASE), 21);
      strobe_off(7'd69);
      check("a4_off", 32'(ACTIVE), 0);

      // note 127: 11 DIVIDE + 1 LOAD, inc = BASE_INC[7] unshifted
      strobe_on(7'd127);
      wait_active(n);
      check("n127_busy_cycles", 32'(n), 12);
      check("n127_inc", 32'(dut.inc), 4384395);
      ce_pulses(50);
      check("n127_phase", 32'(PHASE), 8);
      strobe_off(7'd126);
      check("off_mismatch_active", 32'(ACTIVE), 1);
      strobe_off(7'd127);
      check("off_match_active", 32'(ACTIVE), 0);
      check("off_match_acc", 32'(dut.acc), 0);
      tick();
      check("off_match_phase", 32'(PHASE), 0);

      // retrigger 60 -> 72 with CE running through the division
      strobe_on(7'd60);
      wait_active(n);
      check("n60_busy_cycles", 32'(n), 7);
      check("n60_inc", 32'(dut.inc), 91444);
      ce_pulses(500);
      check("n60_acc_500", 32'(dut.acc), 12167568);
      CE = 1'b1;
      strobe_on(7'd72);
      wait_active(n);
      CE = 1'b0;
      check("retrig_busy_cycles", 32'(n), 8);
      check("retrig_acc_legato", 32'(dut.acc), 12990564);
`ifdef NOTE2PHASE_GLIDE_EN
      check("glide_inc_held", 32'(dut.inc), 91444);
      mono_bad = 1'b0;
      n = 0;
      while (32'(dut.inc) != 182889 && n < 400) begin
         prev_inc = 32'(dut.inc);
         ce_pulses(1);
         if (32'(dut.inc) <= prev_inc || 32'(dut.inc) > 182889)
            mono_bad = 1'b1;
         n++;
      end
      check("glide_monotonic", 32'(mono_bad), 0);
      check("glide_reached", 32'(dut.inc), 182889);
`else
      check("retrig_inc", 32'(dut.inc), 182889);
`endif

      // back to 60, then simultaneous NOTE_ON/NOTE_OFF on the shared NOTE bus
      strobe_on(7'd60);
      wait_active(n);
      NOTE = 7'd64;
      NOTE_ON = 1'b1;
      NOTE_OFF = 1'b1;
      tick();
      NOTE_ON = 1'b0;
      NOTE_OFF = 1'b0;
      check("both_busy", 32'(BUSY), 1);
      check("both_note_q", 32'(dut.note_q), 64);
      seen_idle = 1'b0;
      n = 0;
      while (!ACTIVE && n < 40) begin
         if (!BUSY)
            seen_idle = 1'b1;
         tick();
         n++;
      end
      check("both_never_idle", 32'(seen_idle), 0);
      check("both_active", 32'(ACTIVE), 1);
`ifndef NOTE2PHASE_GLIDE_EN
      check("both_inc", 32'(dut.inc), 115213);
`endif

      // reset in the middle of a division
      strobe_on(7'd127);
      tick();
      check("mid_div_busy", 32'(BUSY), 1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("rst_mid_busy", 32'(BUSY), 0);
      check("rst_mid_active", 32'(ACTIVE), 0);
      check("rst_mid_acc", 32'(dut.acc), 0);
      check("rst_mid_inc", 32'(dut.inc), 0);
      check("rst_mid_note_q", 32'(dut.note_q), 0);
      check("rst_mid_phase", 32'(PHASE), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
